// File: rtl/rr_arb_bs.sv
// 4-requester round-robin arbiter driving the binary select of mux_bs, with
// grant held under a valid/ready handshake. Optional burst lock: RR_ARB_LOCK_EN.
module rr_arb_bs #(
  parameter int MAX_BEATS = 8,
  parameter int CW        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       last,
  input  logic       out_ready,
  output logic       gnt_valid,
  output logic [1:0] bs,
  output logic [3:0] gnt,
  output logic       accept
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic          gnt_valid_q, gnt_valid_d;
  logic [1:0]    bs_q, bs_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [1:0]    win_idle;
  logic [1:0]    win_release;
  logic          any_req;
  logic          release_now;

  // First requester found searching upward from p+1, wrapping 3->0; p itself
  // is considered last, so a lone re-request of the previous owner still wins.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    pick = p;
    for (int i = 4; i >= 1; i--) begin
      idx = p + 2'(i);
      if (r[idx]) pick = idx;
    end
  endfunction

  assign any_req     = |req;
  assign win_idle    = pick(req, ptr_q);
  assign win_release = pick(req, bs_q);
  assign accept      = gnt_valid_q & out_ready;

`ifdef RR_ARB_LOCK_EN
  logic [CW:0] cnt_inc;
  assign cnt_inc     = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};
  assign release_now = last || (cnt_inc >= (CW+1)'(MAX_BEATS));
`else
  logic unused_ok;
  assign release_now = 1'b1;
  assign unused_ok   = ^{last, cnt_q, CW'(MAX_BEATS)};
`endif

  always_comb begin
    state_d     = state_q;
    gnt_valid_d = gnt_valid_q;
    bs_d        = bs_q;
    gnt_d       = gnt_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      IDLE: begin
        gnt_valid_d = 1'b0;
        gnt_d       = 4'b0000;
        if (any_req) begin
          state_d     = GRANT;
          gnt_valid_d = 1'b1;
          bs_d        = win_idle;
          gnt_d       = 4'b0001 << win_idle;
          cnt_d       = '0;
        end
      end

      GRANT: begin
        if (accept) begin
          if (release_now) begin
            ptr_d = bs_q;
            cnt_d = '0;
            // Re-arbitrate with the outgoing owner at lowest priority so a
            // waiting requester takes over without an idle bubble.
            if (any_req) begin
              bs_d  = win_release;
              gnt_d = 4'b0001 << win_release;
            end else begin
              state_d     = IDLE;
              gnt_valid_d = 1'b0;
              gnt_d       = 4'b0000;
            end
          end else begin
`ifdef RR_ARB_LOCK_EN
            if ({1'b0, cnt_q} < (CW+1)'(MAX_BEATS)) cnt_d = cnt_inc[CW-1:0];
`endif
          end
        end
      end

      default: state_d = IDLE;
    endcase

`ifndef RR_ARB_LOCK_EN
    cnt_d = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_valid_q <= 1'b0;
      bs_q        <= 2'd0;
      gnt_q       <= 4'b0000;
      ptr_q       <= 2'd3;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      gnt_valid_q <= gnt_valid_d;
      bs_q        <= bs_d;
      gnt_q       <= gnt_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign gnt_valid = gnt_valid_q;
  assign bs        = bs_q;
  assign gnt       = gnt_q;

endmodule

// File: tb/tb_rr_arb_bs.sv
// Randomized scoreboard bench for rr_arb_bs; the expected grant per cycle comes
// from a round-robin model written in terms of owner / last-served requester.
module tb_rr_arb_bs;

  localparam int MAX_BEATS = 4;
  localparam int CW        = 8;
`ifdef RR_ARB_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       last;
  logic       out_ready;
  logic       gnt_valid;
  logic [1:0] bs;
  logic [3:0] gnt;
  logic       accept;

  rr_arb_bs #(.MAX_BEATS(MAX_BEATS), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .last     (last),
    .out_ready(out_ready),
    .gnt_valid(gnt_valid),
    .bs       (bs),
    .gnt      (gnt),
    .accept   (accept)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       gv;
    logic [1:0] bs;
    logic [3:0] gnt;
    logic       acc;
  } exp_t;

  exp_t expQ[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: who owns the mux now, who was served last, beats so far
  bit m_known = 1'b0;
  int m_owner = -1;
  int m_bs    = 0;
  int m_last  = 3;
  int m_beats = 0;

  function automatic int winner(input logic [3:0] r, input int from);
    for (int off = 1; off <= 4; off++) begin
      int k;
      k = (from + off) % 4;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  task automatic applyStimulus(input logic r, input logic [3:0] rq,
                               input logic ordy, input logic lst);
    exp_t e;
    int   w;
    bit   done;
    @(posedge clk);
    #1;
    rst       = r;
    req       = rq;
    out_ready = ordy;
    last      = lst;
    if (m_known) begin
      e.gv  = (m_owner >= 0);
      e.bs  = 2'(m_bs);
      e.gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      e.acc = e.gv & ordy;
      expQ.push_back(e);
    end
    if (r) begin
      m_known = 1'b1;
      m_owner = -1;
      m_bs    = 0;
      m_last  = 3;
      m_beats = 0;
    end else if (m_owner < 0) begin
      w = winner(rq, m_last);
      if (w >= 0) begin
        m_owner = w;
        m_bs    = w;
      end
    end else if (ordy) begin
      m_beats++;
      done = !LOCK || lst || (m_beats >= MAX_BEATS);
      if (done) begin
        m_last  = m_owner;
        m_beats = 0;
        w = winner(rq, m_last);
        if (w >= 0) begin
          m_owner = w;
          m_bs    = w;
        end else begin
          m_owner = -1;
        end
      end
    end
  endtask

  task automatic checkOutput(input exp_t e);
    tests++;
    if (gnt_valid !== e.gv || bs !== e.bs || gnt !== e.gnt || accept !== e.acc) begin
      fails++;
      $display("[TB] FAIL grant t=%0t: got gv=%b bs=%0d gnt=%b acc=%b, expected gv=%b bs=%0d gnt=%b acc=%b",
               $time, gnt_valid, bs, gnt, accept, e.gv, e.bs, e.gnt, e.acc);
    end
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    rst = 1'b1; req = 4'b0000; out_ready = 1'b0; last = 1'b0;
    repeat (2) applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);

    // Single requester, then reset while a grant is held
    applyStimulus(1'b0, 4'b0001, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
    repeat (2) applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'b1000, 1'b0, 1'b0);
    repeat (2) applyStimulus(1'b0, 4'b1000, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b1000, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);

    // All four requesting: 0,1,2,3,0,...
    repeat (10) applyStimulus(1'b0, 4'b1111, 1'b1, 1'b1);
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);

    // Held grant under backpressure, then single accept
    repeat (6) applyStimulus(1'b0, 4'b0100, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b0100, 1'b1, 1'b1);
    repeat (2) applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);

    // Wrap from requester 1 to 0, then lone re-grant of 1
    applyStimulus(1'b0, 4'b0010, 1'b1, 1'b1);
    applyStimulus(1'b0, 4'b0011, 1'b1, 1'b1);
    repeat (2) applyStimulus(1'b0, 4'b0010, 1'b1, 1'b1);
    repeat (2) applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);

    // Burst traffic on 0/1 with and without an early last
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
    repeat (12) applyStimulus(1'b0, 4'b0011, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b0011, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'b0011, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'b0011, 1'b1, 1'b1);
    repeat (6) applyStimulus(1'b0, 4'b0011, 1'b1, 1'b0);

    // Random traffic with occasional reset
    for (int n = 0; n < 3000; n++) begin
      applyStimulus(($urandom_range(199) == 0), 4'($urandom_range(15)),
                    ($urandom_range(9) < 7), ($urandom_range(9) < 3));
    end

    repeat (3) applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    tests++;
    if (expQ.size() != 0) begin
      fails++;
      $display("[TB] FAIL drain: %0d expected records left, required 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rr_arb_bs.md
Name: rr_arb_bs

Overview:
- 4-requester round-robin arbiter that sits directly upstream of the 4-input binary-select mux (mux_bs).
- Produces the registered 2-bit binary select `bs` and a one-hot grant.
- Holds the grant stable under a valid/ready handshake with the downstream consumer of the mux output.
- One arbitration decision per accepted beat; back-to-back grants are sustained at 1 beat/cycle.

Parameters:
- MAX_BEATS, 8, maximum beats a locked grant may hold before forced release (used only with RR_ARB_LOCK_EN); legal range 1..255.
- CW, 8, width of the internal beat counter; must hold MAX_BEATS.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- req  in  4  request per mux input; req[i] selects in_i of mux_bs.
- last  in  1  end-of-burst marker for the beat currently granted; sampled only on accept.
- out_ready  in  1  downstream accepts the current beat.
- gnt_valid  out  1  a grant is active; bs/gnt are meaningful.
- bs  out  2  binary select to mux_bs; equals the index of the granted requester.
- gnt  out  4  one-hot grant; 0 when gnt_valid=0.
- accept  out  1  combinational gnt_valid & out_ready; pulses once per consumed beat.

Behaviour:
- Reset (rst=1 at edge): gnt_valid=0, bs=0, gnt=0, ptr=3 so requester 0 has first priority, beat counter=0, state=IDLE. Reset overrides everything, including a grant held mid-burst.
- Priority search: starting at (ptr+1) mod 4, ascending and wrapping 3->0, the first i with req[i]=1 wins.
- States:
  - IDLE: gnt_valid=0. If |req=1, the winner is registered, so the next cycle has gnt_valid=1, bs=winner, gnt=1<<winner, state=GRANT. Latency from request to grant is 1 cycle.
  - GRANT: bs/gnt must remain constant while out_ready=0, even if req[bs] drops; requesters must not withdraw. On accept, ptr<=bs. The beat counter is handled per the optional feature.
- Grant release on accept, when not locked:
  - |req=1: re-arbitrate in the same cycle using ptr=bs (the current grant gets lowest priority). New grant appears next cycle; gnt_valid stays 1 with no bubble.
  - |req=0: next cycle gnt_valid=0, state=IDLE. bs holds its last value; gnt=0.
- Simultaneous events:
  - A requester that was just served and is still requesting gets re-granted only when no other requester is asserted.
  - All four requesting gives a 0,1,2,3,0,... sequence, one per accept.
- Beat counter: CW bits, saturating at MAX_BEATS. Cleared on every grant change and on reset.
- No bubbles and no combinational path from req to bs/gnt/gnt_valid; all three are registered.

Optional Feature:
- Macro: RR_ARB_LOCK_EN.
- Defined (burst lock):
  - After accept with last=0, the grant stays on the same requester (ptr not advanced) and the beat counter increments.
  - Release follows the rules above on accept with last=1, or on the accept that makes the counter reach MAX_BEATS (forced release even if last=0). The counter then clears.
  - While locked, other requests are ignored.
- Undefined: every accept releases; `last` is ignored; the counter stays 0; MAX_BEATS is unused.

Test Plan:
- Reset then req=4'b0001, out_ready=1 -> gnt_valid=1, bs=0, gnt=0001 one cycle after req. Reset mid-grant with rst=1 -> gnt_valid=0, bs=0 next cycle.
- req=4'b1111, out_ready=1 held for 8 cycles -> bs sequence 0,1,2,3,0,1,2,3; accept=1 every cycle after the first grant.
- req=4'b0100, out_ready=0 for 5 cycles, then 1 -> bs=2 stable all 5 cycles; one accept; gnt_valid=0 the cycle after if req cleared.
- Grant on 1 (ptr=1) with req=4'b0011 -> next grant bs=0 (wrap). Then req=4'b0010 alone -> bs=1 re-granted.
- RR_ARB_LOCK_EN, MAX_BEATS=4, req=4'b0011, last=0 throughout -> bs=0 for 4 accepts, then bs=1. With last=1 on the 2nd accept -> bs switches to 1 after 2 beats.
- Without RR_ARB_LOCK_EN, same stimulus as the previous scenario -> bs alternates 0,1,0,1 regardless of last.
